// File: rtl/alu_mul_seq_pkg.sv
// Shared ALU control codes and multiply sequencer state encoding.
// Also used by the main control unit when it drives alu32 itself.
package alu_mul_seq_pkg;

  localparam logic [2:0] GIN_ADD  = 3'b010;
  localparam logic [2:0] GIN_SLL  = 3'b100;
  localparam logic [2:0] GIN_IDLE = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ADD   = 2'b01,
    S_SHIFT = 2'b10,
    S_DONE  = 2'b11
  } mul_state_e;

  // Entry state for a newly accepted multiplier value.
  function automatic mul_state_e entry_state(
    input logic [31:0] b
  );
    mul_state_e s;
    s = S_SHIFT;
    if (b == 32'd0) s = S_DONE;
    else if (b[0]) s = S_ADD;
    return s;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiply sequencer driving the shared alu32.
// Produces the low 32 bits of op_a*op_b; busy gates the ALU mux.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_gin,
  input  logic [31:0] alu_sum
);

  mul_state_e  r_state;
  logic [31:0] r_acc;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic        r_done;
  logic [31:0] r_result;

  logic [31:0] w_alu_a;
  logic [31:0] w_alu_b;
  logic [2:0]  w_gin;

  // ALU steering is a pure decode of registered state.
  always_comb begin
    w_alu_a = 32'd0;
    w_alu_b = 32'd0;
    w_gin   = GIN_IDLE;
    unique case (r_state)
      S_ADD: begin
        w_alu_a = r_acc;
        w_alu_b = r_mcand;
        w_gin   = GIN_ADD;
      end
      S_SHIFT: begin
        w_alu_a = r_mcand;
        w_alu_b = 32'd1;
        w_gin   = GIN_SLL;
      end
      default: begin
        w_alu_a = 32'd0;
        w_alu_b = 32'd0;
        w_gin   = GIN_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_acc    <= 32'd0;
      r_mcand  <= 32'd0;
      r_mplier <= 32'd0;
      r_done   <= 1'b0;
      r_result <= 32'd0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc    <= 32'd0;
            r_mcand  <= op_a;
            r_mplier <= op_b;
            r_state  <= entry_state(op_b);
          end
        end
        S_ADD: begin
          r_acc <= alu_sum;
          if (r_mplier == 32'd1) r_state <= S_DONE;
          else r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_mcand  <= alu_sum;
          r_mplier <= r_mplier >> 1;
          // Bit 1 is the next multiplier LSB after this shift.
          if (r_mplier[1]) r_state <= S_ADD;
          else r_state <= S_SHIFT;
        end
        S_DONE: begin
          r_result <= r_acc;
          r_done   <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign result  = r_result;
  assign alu_a   = w_alu_a;
  assign alu_b   = w_alu_b;
  assign alu_gin = w_gin;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural alu32 model.
// Expected products and latencies are queued at launch and popped at done.
module tb_alu_mul_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_gin;
  logic [31:0] alu_sum;

  int total = 0;
  int bad   = 0;

  logic [31:0] q_res[$];
  int          q_lat[$];
  logic [2:0]  gins[$];

  alu_mul_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_gin (alu_gin),
    .alu_sum (alu_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    alu_sum = alu_a & alu_b;
    if (alu_gin == 3'b010) alu_sum = alu_a + alu_b;
    else if (alu_gin == 3'b100) alu_sum = alu_a << alu_b[4:0];
  end

  function automatic int exp_edges(input logic [31:0] b);
    int pc;
    int hi;
    pc = 0;
    hi = 0;
    for (int i = 0; i < 32; i++)
      if (b[i]) begin
        pc++;
        hi = i;
      end
    if (b == 32'd0) return 1;
    return pc + hi + 1;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives start for one edge (E0); returns just after E0.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] p;
    p = a * b;
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    q_res.push_back(p);
    q_lat.push_back(exp_edges(b));
    gins.delete();
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
    if (busy) gins.push_back(alu_gin);
  endtask

  // Waits for done, optionally pulsing start at edge count poke.
  task automatic wait_done(input string tag, input int poke);
    int n;
    logic [31:0] er;
    int el;
    n = 0;
    while (n < 200) begin
      if (n == poke) begin
        start = 1'b1;
        op_a  = 32'h0000_0003;
        op_b  = 32'h0000_0003;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
      if (done) break;
      if (busy) gins.push_back(alu_gin);
    end
    chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    er = q_res.pop_front();
    el = q_lat.pop_front();
    chk({tag, "_latency"}, n, el);
    chk({tag, "_result"}, result, er);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op_a  = 32'd0;
    op_b  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_gin", {29'd0, alu_gin}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);

    launch(32'd3, 32'd5);
    chk("m35_add_a", alu_a, 32'd0);
    chk("m35_add_b", alu_b, 32'd3);
    wait_done("m35", -1);
    chk("m35_nsteps", gins.size(), 32'd5);
    if (gins.size() == 5) begin
      chk("m35_gin0", {29'd0, gins[0]}, 32'd2);
      chk("m35_gin1", {29'd0, gins[1]}, 32'd4);
      chk("m35_gin2", {29'd0, gins[2]}, 32'd4);
      chk("m35_gin3", {29'd0, gins[3]}, 32'd2);
      chk("m35_gin4", {29'd0, gins[4]}, 32'd0);
    end
    @(posedge clk);
    #1;
    chk("m35_done_drop", {31'd0, done}, 32'd0);
    chk("m35_idle", {31'd0, busy}, 32'd0);
    chk("m35_hold", result, 32'd15);

    launch(32'hFFFF_FFFD, 32'd7);
    wait_done("neg3x7", -1);
    chk("neg3x7_lit", result, 32'hFFFF_FFEB);
    @(posedge clk);
    #1;

    launch(32'h1234_5678, 32'd0);
    wait_done("b0", -1);
    chk("b0_lit", result, 32'd0);
    @(posedge clk);
    #1;

    launch(32'h8000_0001, 32'hFFFF_FFFF);
    wait_done("wrap", 20);
    chk("wrap_lit", result, 32'h7FFF_FFFF);

    // Back-to-back: second request in the done cycle.
    launch(32'd6, 32'd2);
    chk("b2b_done_drop", {31'd0, done}, 32'd0);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done("b2b", -1);
    chk("b2b_lit", result, 32'd12);
    @(posedge clk);
    #1;

    launch(32'd9, 32'h0000_0100);
    void'(q_res.pop_back());
    void'(q_lat.pop_back());
    @(posedge clk);
    #1;
    chk("abort_gin", {29'd0, alu_gin}, 32'd4);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_result", result, 32'd0);
    begin
      logic seen;
      seen = 1'b0;
      repeat (12) begin
        @(posedge clk);
        #1;
        seen = seen | done;
      end
      chk("abort_no_done", {31'd0, seen}, 32'd0);
    end

    launch(32'd4, 32'd4);
    wait_done("m44", -1);
    chk("m44_lit", result, 32'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
